// File: rtl/rename_map_if.sv
`default_nettype none
// ============================================================================
// rename_map_if : issue / lookup / commit / recovery bundle for rename_map
// Revision 1.0
// ============================================================================
interface rename_map_if #(
  parameter int NUM_WR   = 2,
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 6,
  parameter int NUM_CKPT = 4
);
  localparam int NUM_RD = 2 * NUM_WR;
  localparam int REG_W  = $clog2(NUM_REGS);
  localparam int CKPT_W = $clog2(NUM_CKPT);

  logic                             IN_valid;
  logic                             OUT_ready;
  logic [NUM_RD-1:0][REG_W-1:0]     IN_rdReg;
  logic [NUM_WR-1:0][REG_W-1:0]     IN_wrReg;
  logic                             IN_ckptSave;

  logic [NUM_RD-1:0][31:0]          OUT_rdValue;
  logic [NUM_RD-1:0][TAG_W-1:0]     OUT_rdTag;
  logic [NUM_RD-1:0]                OUT_rdAvail;
  logic [NUM_WR-1:0][TAG_W-1:0]     OUT_wrTag;
  logic [CKPT_W-1:0]                OUT_ckptId;

  logic [NUM_WR-1:0]                IN_wbValid;
  logic [NUM_WR-1:0][REG_W-1:0]     IN_wbReg;
  logic [NUM_WR-1:0][TAG_W-1:0]     IN_wbTag;
  logic [NUM_WR-1:0][31:0]          IN_wbResult;

  logic                             IN_branchTaken;
  logic [CKPT_W-1:0]                IN_branchCkpt;
  logic [TAG_W-1:0]                 IN_branchTag;
  logic                             IN_ckptFree;

  modport master (
    output IN_valid, IN_rdReg, IN_wrReg, IN_ckptSave,
    output IN_wbValid, IN_wbReg, IN_wbTag, IN_wbResult,
    output IN_branchTaken, IN_branchCkpt, IN_branchTag, IN_ckptFree,
    input  OUT_ready, OUT_rdValue, OUT_rdTag, OUT_rdAvail, OUT_wrTag, OUT_ckptId
  );

  modport slave (
    input  IN_valid, IN_rdReg, IN_wrReg, IN_ckptSave,
    input  IN_wbValid, IN_wbReg, IN_wbTag, IN_wbResult,
    input  IN_branchTaken, IN_branchCkpt, IN_branchTag, IN_ckptFree,
    output OUT_ready, OUT_rdValue, OUT_rdTag, OUT_rdAvail, OUT_wrTag, OUT_ckptId
  );
endinterface
`default_nettype wire

// File: rtl/rename_map.sv
`default_nettype none
// ============================================================================
// rename_map : register rename table with bypass, commit and branch checkpoints
// Revision 1.0
// ============================================================================
module rename_map #(
  parameter int NUM_WR   = 2,
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 6,
  parameter int NUM_CKPT = 4
) (
  input  logic         clk,
  input  logic         rst,
  rename_map_if.slave  bus
);
  localparam int NUM_RD = 2 * NUM_WR;
  localparam int CKPT_W = $clog2(NUM_CKPT);
  localparam int CNT_W  = $clog2(NUM_CKPT + 1);

  typedef logic [NUM_REGS-1:0][TAG_W-1:0] tag_map_t;

  tag_map_t                         map_tag;
  logic [NUM_REGS-1:0]              map_avail;
  logic [NUM_REGS-1:0][31:0]        map_value;
  tag_map_t [NUM_CKPT-1:0]          ckpt_tag;
  logic [NUM_CKPT-1:0][NUM_REGS-1:0] ckpt_avail;
  logic [TAG_W-1:0]                 tag_cnt;
  logic [CKPT_W-1:0]                head, tail;
  logic [CNT_W-1:0]                 count;

  logic [NUM_REGS-1:0]              wb_hit, commit_set, base_avail, nxt_avail;
  tag_map_t                         wb_tag, base_tag, nxt_tag;
  logic [NUM_REGS-1:0][31:0]        wb_val, nxt_value;
  logic [NUM_WR-1:0][TAG_W-1:0]     wr_tag;
  logic [NUM_RD-1:0][31:0]          rd_value;
  logic [NUM_RD-1:0][TAG_W-1:0]     rd_tag;
  logic [NUM_RD-1:0]                rd_avail;
  logic [NUM_CKPT-1:0][CKPT_W-1:0]  ckpt_dist;
  logic [NUM_CKPT-1:0]              ckpt_valid;
  logic [CKPT_W-1:0]                head_nxt, br_dist;
  logic                             ready, accept, save_acc, free_ok;

  // Per-register winning commit: later write ports overwrite earlier ones.
  always_comb begin
    wb_hit = '0;
    wb_tag = '0;
    wb_val = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (bus.IN_wbValid[i] && bus.IN_wbReg[i] != '0) begin
        wb_hit[bus.IN_wbReg[i]] = 1'b1;
        wb_tag[bus.IN_wbReg[i]] = bus.IN_wbTag[i];
        wb_val[bus.IN_wbReg[i]] = bus.IN_wbResult[i];
      end
    end
  end

  assign ready    = !bus.IN_branchTaken &&
                    !(bus.IN_ckptSave && count == CNT_W'(NUM_CKPT));
  assign accept   = bus.IN_valid && ready;
  assign save_acc = accept && bus.IN_ckptSave;
  assign free_ok  = bus.IN_ckptFree && count != '0;
  assign head_nxt = free_ok ? head + CKPT_W'(1) : head;
  assign br_dist  = bus.IN_branchCkpt - head_nxt;

  always_comb begin
    for (int i = 0; i < NUM_WR; i++) wr_tag[i] = tag_cnt + TAG_W'(i);
  end

  always_comb begin
    rd_value = '0;
    rd_tag   = '0;
    rd_avail = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_value[k] = map_value[bus.IN_rdReg[k]];
      rd_tag[k]   = map_tag[bus.IN_rdReg[k]];
      rd_avail[k] = map_avail[bus.IN_rdReg[k]];
      if (wb_hit[bus.IN_rdReg[k]] && wb_tag[bus.IN_rdReg[k]] == map_tag[bus.IN_rdReg[k]]) begin
        rd_value[k] = wb_val[bus.IN_rdReg[k]];
        rd_avail[k] = 1'b1;
      end
      // Only older instructions in the bundle may feed a reader.
      for (int j = 0; j < NUM_WR; j++) begin
        if (j < k / 2 && bus.IN_valid && bus.IN_wrReg[j] == bus.IN_rdReg[k]) begin
          rd_tag[k]   = wr_tag[j];
          rd_avail[k] = 1'b0;
        end
      end
      if (bus.IN_rdReg[k] == '0) begin
        rd_value[k] = '0;
        rd_tag[k]   = '0;
        rd_avail[k] = 1'b1;
      end
    end
  end

  // Commits match against the restored map when a branch recovers this cycle.
  always_comb begin
    base_tag   = bus.IN_branchTaken ? ckpt_tag[bus.IN_branchCkpt]   : map_tag;
    base_avail = bus.IN_branchTaken ? ckpt_avail[bus.IN_branchCkpt] : map_avail;
    commit_set = '0;
    nxt_value  = map_value;
    for (int r = 0; r < NUM_REGS; r++) begin
      commit_set[r] = wb_hit[r] && wb_tag[r] == base_tag[r];
      if (wb_hit[r]) nxt_value[r] = wb_val[r];
    end
    nxt_tag   = base_tag;
    nxt_avail = base_avail | commit_set;
    if (accept) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.IN_wrReg[i] != '0) begin
          nxt_tag[bus.IN_wrReg[i]]   = wr_tag[i];
          nxt_avail[bus.IN_wrReg[i]] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_CKPT; s++) begin
      ckpt_dist[s]  = CKPT_W'(s) - head;
      ckpt_valid[s] = CNT_W'(ckpt_dist[s]) < count;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      map_tag    <= '0;
      map_avail  <= '1;
      map_value  <= '0;
      ckpt_tag   <= '0;
      ckpt_avail <= '1;
      tag_cnt    <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      map_tag   <= nxt_tag;
      map_avail <= nxt_avail;
      map_value <= nxt_value;
      for (int s = 0; s < NUM_CKPT; s++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          if (ckpt_valid[s] && commit_set[r] && ckpt_tag[s][r] == wb_tag[r])
            ckpt_avail[s][r] <= 1'b1;
        end
      end
      if (save_acc) begin
        ckpt_tag[tail]   <= nxt_tag;
        ckpt_avail[tail] <= nxt_avail;
      end
      head <= head_nxt;
      if (bus.IN_branchTaken) begin
        tag_cnt <= bus.IN_branchTag + TAG_W'(1);
        tail    <= bus.IN_branchCkpt + CKPT_W'(1);
        count   <= CNT_W'(br_dist) + CNT_W'(1);
      end else begin
        if (accept)   tag_cnt <= tag_cnt + TAG_W'(NUM_WR);
        if (save_acc) tail    <= tail + CKPT_W'(1);
        if (save_acc && !free_ok)      count <= count + CNT_W'(1);
        else if (!save_acc && free_ok) count <= count - CNT_W'(1);
      end
    end
  end

  assign bus.OUT_ready   = ready;
  assign bus.OUT_wrTag   = wr_tag;
  assign bus.OUT_ckptId  = tail;
  assign bus.OUT_rdValue = rd_value;
  assign bus.OUT_rdTag   = rd_tag;
  assign bus.OUT_rdAvail = rd_avail;
endmodule
`default_nettype wire

// File: tb/tb_rename_map.sv
`default_nettype none
// ============================================================================
// tb_rename_map : scoreboard bench for rename_map against a behavioural model
// Revision 1.0
// ============================================================================
module tb_rename_map;
  localparam int NR = 32;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rename_map_if bus ();
  rename_map dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic             ready;
    logic [1:0][5:0]  wtag;
    logic [1:0]       ck;
    logic [3:0][31:0] val;
    logic [3:0][5:0]  tag;
    logic [3:0]       av;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Stimulus for the cycle being driven.
  bit          s_rst, s_valid, s_save, s_br, s_free;
  int          s_rd[4], s_wr[2], s_wbr[2], s_wbt[2], s_brck, s_brtag;
  bit          s_wbv[2];
  logic [31:0] s_wbres[2];

  // Reference model: architectural view of the table.
  int          m_tag[NR];
  bit          m_av[NR];
  logic [31:0] m_val[NR];
  int          c_tag[NC][NR];
  bit          c_av[NC][NR];
  int          m_cnt, m_head, m_tail, m_count;

  task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic int last_wb(int r);
    for (int i = 1; i >= 0; i--)
      if (s_wbv[i] && s_wbr[i] == r) return i;
    return -1;
  endfunction

  task automatic clear_stim();
    s_rst = 1; s_valid = 0; s_save = 0; s_br = 0; s_free = 0;
    s_brck = 0; s_brtag = 0;
    for (int k = 0; k < 4; k++) s_rd[k] = 0;
    for (int i = 0; i < 2; i++) begin
      s_wr[i] = 0; s_wbr[i] = 0; s_wbt[i] = 0; s_wbv[i] = 0; s_wbres[i] = 0;
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_tag[r] = 0; m_av[r] = 1; m_val[r] = 0;
      for (int s = 0; s < NC; s++) begin c_tag[s][r] = 0; c_av[s][r] = 1; end
    end
    m_cnt = 0; m_head = 0; m_tail = 0; m_count = 0;
  endtask

  function automatic exp_t predict();
    exp_t e;
    int r, w;
    e.ready = !(s_br || (s_save && m_count == NC));
    for (int i = 0; i < 2; i++) e.wtag[i] = 6'((m_cnt + i) % 64);
    e.ck = 2'(m_tail);
    for (int k = 0; k < 4; k++) begin
      r = s_rd[k];
      e.val[k] = m_val[r]; e.tag[k] = 6'(m_tag[r]); e.av[k] = m_av[r];
      w = last_wb(r);
      if (r != 0 && w >= 0 && s_wbt[w] == m_tag[r]) begin
        e.val[k] = s_wbres[w]; e.av[k] = 1'b1;
      end
      if (s_valid)
        for (int j = k / 2 - 1; j >= 0; j--)
          if (r != 0 && s_wr[j] == r) begin
            e.tag[k] = e.wtag[j]; e.av[k] = 1'b0; break;
          end
      if (r == 0) begin e.val[k] = 0; e.tag[k] = 0; e.av[k] = 1; end
    end
    return e;
  endfunction

  task automatic model_update(bit ready);
    int nt[NR];
    bit na[NR];
    int w, s, nh;
    bit acc, free_ok;
    if (!s_rst) begin model_reset(); return; end
    acc = s_valid && ready;
    for (int r = 0; r < NR; r++) begin
      nt[r] = s_br ? c_tag[s_brck][r] : m_tag[r];
      na[r] = s_br ? c_av[s_brck][r]  : m_av[r];
    end
    for (int r = 1; r < NR; r++) begin
      w = last_wb(r);
      if (w >= 0) begin
        m_val[r] = s_wbres[w];
        if (s_wbt[w] == nt[r]) begin
          na[r] = 1;
          for (int n = 0; n < m_count; n++) begin
            s = (m_head + n) % NC;
            if (c_tag[s][r] == s_wbt[w]) c_av[s][r] = 1;
          end
        end
      end
    end
    if (acc)
      for (int i = 0; i < 2; i++)
        if (s_wr[i] != 0) begin nt[s_wr[i]] = (m_cnt + i) % 64; na[s_wr[i]] = 0; end
    for (int r = 0; r < NR; r++) begin
      m_tag[r] = nt[r]; m_av[r] = na[r];
      if (acc && s_save) begin c_tag[m_tail][r] = nt[r]; c_av[m_tail][r] = na[r]; end
    end
    free_ok = s_free && m_count > 0;
    nh = free_ok ? (m_head + 1) % NC : m_head;
    if (s_br) begin
      m_cnt   = (s_brtag + 1) % 64;
      m_tail  = (s_brck + 1) % NC;
      m_count = ((s_brck - nh + NC) % NC) + 1;
    end else begin
      if (acc) m_cnt = (m_cnt + 2) % 64;
      if (acc && s_save) begin m_tail = (m_tail + 1) % NC; m_count++; end
      if (free_ok) m_count--;
    end
    m_head = nh;
  endtask

  task automatic step(bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s_rst;
    bus.IN_valid = s_valid; bus.IN_ckptSave = s_save;
    bus.IN_branchTaken = s_br; bus.IN_branchCkpt = 2'(s_brck);
    bus.IN_branchTag = 6'(s_brtag); bus.IN_ckptFree = s_free;
    for (int k = 0; k < 4; k++) bus.IN_rdReg[k] = 5'(s_rd[k]);
    for (int i = 0; i < 2; i++) begin
      bus.IN_wrReg[i] = 5'(s_wr[i]); bus.IN_wbValid[i] = s_wbv[i];
      bus.IN_wbReg[i] = 5'(s_wbr[i]); bus.IN_wbTag[i] = 6'(s_wbt[i]);
      bus.IN_wbResult[i] = s_wbres[i];
    end
    e = predict();
    if (chk) exp_q.push_back(e);
    model_update(e.ready);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ready", 32'(bus.OUT_ready), 32'(e.ready));
      check("ckptId", 32'(bus.OUT_ckptId), 32'(e.ck));
      for (int i = 0; i < 2; i++)
        check($sformatf("wrTag[%0d]", i), 32'(bus.OUT_wrTag[i]), 32'(e.wtag[i]));
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rdTag[%0d]", k), 32'(bus.OUT_rdTag[k]), 32'(e.tag[k]));
        check($sformatf("rdAvail[%0d]", k), 32'(bus.OUT_rdAvail[k]), 32'(e.av[k]));
        if (e.av[k]) check($sformatf("rdValue[%0d]", k), bus.OUT_rdValue[k], e.val[k]);
      end
    end
  end

  function automatic int pick_reg();
    return ($urandom_range(3) == 0) ? int'($urandom_range(31)) : int'($urandom_range(7));
  endfunction

  task automatic rand_stim();
    int sel;
    clear_stim();
    s_rst   = ($urandom_range(99) != 0);
    s_valid = ($urandom_range(9) < 7);
    s_save  = ($urandom_range(9) < 3);
    for (int k = 0; k < 4; k++) s_rd[k] = pick_reg();
    for (int i = 0; i < 2; i++) begin
      s_wr[i]    = pick_reg();
      s_wbv[i]   = $urandom_range(1) == 1;
      s_wbr[i]   = pick_reg();
      s_wbres[i] = $urandom;
      sel = $urandom_range(9);
      if (sel < 6)      s_wbt[i] = m_tag[s_wbr[i]];
      else if (sel < 8) s_wbt[i] = c_tag[$urandom_range(NC-1)][s_wbr[i]];
      else              s_wbt[i] = $urandom_range(63);
    end
    if (m_count > 0 && $urandom_range(9) == 0) begin
      s_br    = 1;
      s_brck  = (m_head + int'($urandom_range(m_count - 1))) % NC;
      s_brtag = $urandom_range(63);
    end else begin
      s_free = ($urandom_range(9) == 0);
    end
  endtask

  task automatic do_reset();
    clear_stim(); s_rst = 0; step(1);
  endtask

  initial begin
    model_reset();
    clear_stim(); s_rst = 0; step(0);
    do_reset();
    // Rename x5, then read it back; x3/x4 intra-bundle bypass; x0 writes.
    clear_stim(); s_valid = 1; s_wr[0] = 5; step(1);
    clear_stim(); s_rd[0] = 5; step(1);
    clear_stim(); s_valid = 1; s_wr[0] = 3; s_wr[1] = 4; s_rd[2] = 3; step(1);
    clear_stim(); s_valid = 1; s_rd[0] = 0; s_rd[1] = 3; step(1);
    // Re-rename x5 to tag 6, then commit stale tag 0 and current tag 6.
    clear_stim(); s_valid = 1; s_wr[0] = 5; step(1);
    clear_stim(); s_wbv[0] = 1; s_wbr[0] = 5; s_wbt[0] = 0; s_wbres[0] = 32'hDEADBEEF; s_rd[0] = 5; step(1);
    clear_stim(); s_wbv[1] = 1; s_wbr[1] = 5; s_wbt[1] = 6; s_wbres[1] = 32'h12345678; s_rd[0] = 5; step(1);
    clear_stim(); s_rd[0] = 5; step(1);
    // Fill all checkpoints, overflow with a same-cycle free, then save again.
    for (int n = 0; n < 4; n++) begin clear_stim(); s_valid = 1; s_save = 1; step(1); end
    clear_stim(); s_valid = 1; s_save = 1; s_free = 1; step(1);
    clear_stim(); s_valid = 1; s_save = 1; step(1);
    // Branch recovery restoring x7.
    do_reset();
    clear_stim(); s_valid = 1; s_save = 1; step(1);
    clear_stim(); s_valid = 1; s_save = 1; s_wr[0] = 7; step(1);
    clear_stim(); s_valid = 1; s_wr[1] = 7; s_rd[0] = 7; step(1);
    clear_stim(); s_br = 1; s_brck = 1; s_brtag = 9; s_valid = 1; s_save = 1; s_wr[0] = 7; s_rd[0] = 7; step(1);
    clear_stim(); s_valid = 1; s_rd[0] = 7; step(1);
    for (int n = 0; n < 3; n++) begin clear_stim(); s_valid = 1; s_save = 1; step(1); end
    // Tag counter wrap, then reset in the middle of a busy cycle.
    do_reset();
    for (int n = 0; n < 33; n++) begin clear_stim(); s_valid = 1; s_wr[0] = 1 + n % 7; step(1); end
    clear_stim(); s_rst = 0; s_valid = 1; s_wr[0] = 2; s_save = 1; s_br = 1;
    s_wbv[0] = 1; s_wbr[0] = 2; s_wbres[0] = 32'hFFFF0000; step(1);
    clear_stim(); s_rd[0] = 2; s_rd[1] = 1; step(1);
    for (int n = 0; n < 3000; n++) begin rand_stim(); step(1); end
    clear_stim(); step(1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
